// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// Holds the state encoding, the counter-width helper and the loss-count ceiling.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } pll_state_e;

  localparam logic [7:0] LOSS_SAT = 8'hFF;

  // Width of a counter that has to reach the largest of three terminal values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous status bit.
// Both stages clear to 0 on reset, so a stale input never appears after reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the PLL: pulses PLL_RESETB, qualifies lock,
// and holds the core in reset until lock has been stable long enough.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RST_PLL | PLL_RESETB low for RESET_CYCLES cycles
// ST_WAIT    | PLL running, waiting for synchronized lock (timeout armed)
// ST_STABLE  | lock seen, counting consecutive lock-high cycles
// ST_RUN     | core released, LOCKED high, watching for lock loss
// ST_FAULT   | retries exhausted, PLL held in reset until RESTART/RESET
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       RESTART,
  input  logic       PLL_LOCK,
  output logic       PLL_RESETB,
  output logic       CORE_RESET,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [1:0] RETRY_COUNT,
  output logic [7:0] LOSS_COUNT
);

  localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk (REFERENCECLK),
    .rst (RESET),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state_q <= ST_RST_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // One phase counter is shared; every state change restarts it from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (RESTART) begin
      state_d = ST_RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          // Lock is checked first so it wins over an expiring timeout.
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = '0;
            state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RST_PLL;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = ST_RST_PLL;
            if (loss_q != LOSS_SAT) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RST_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    PLL_RESETB  = (state_q != ST_RST_PLL) && (state_q != ST_FAULT);
    CORE_RESET  = (state_q != ST_RUN);
    LOCKED      = (state_q == ST_RUN);
    FAULT       = (state_q == ST_FAULT);
    RETRY_COUNT = retry_q;
    LOSS_COUNT  = loss_q;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with small sequencing parameters.
// Expected timings are derived from cycle arithmetic on the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int RC    = 4;
  localparam int LT    = 32;
  localparam int LS    = 8;
  localparam int MR    = 2;
  localparam int BOUND = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb, core_reset, locked, fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .MAX_RETRIES  (MR)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .RESTART      (restart),
    .PLL_LOCK     (pll_lock),
    .PLL_RESETB   (pll_resetb),
    .CORE_RESET   (core_reset),
    .LOCKED       (locked),
    .FAULT        (fault),
    .RETRY_COUNT  (retry_count),
    .LOSS_COUNT   (loss_count)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    restart  = 1'b0;
    pll_lock = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_resetb"}, int'(pll_resetb), 0);
    check_eq({tag, "_core"},   int'(core_reset), 1);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_fault"},  int'(fault), 0);
    check_eq({tag, "_retry"},  int'(retry_count), 0);
    check_eq({tag, "_loss"},   int'(loss_count), 0);
  endtask

  // Counts low samples of PLL_RESETB (current one included); returns on the first high.
  task automatic wait_resetb_rise(output int low);
    low = 0;
    while (pll_resetb == 1'b0 && low < BOUND) begin
      low++;
      step(1);
    end
  endtask

  task automatic steps_until_locked(output int k, output int retry_before);
    k = 0;
    retry_before = int'(retry_count);
    while (locked == 1'b0 && k < BOUND) begin
      retry_before = int'(retry_count);
      step(1);
      k++;
    end
  endtask

  // PLL_LOCK rises d cycles after PLL_RESETB rises (W = that rising sample).
  // Lock is sampled at W+d+1 and reaches the sequencer decision at W+d+3; a
  // decision at or before the timeout edge (W+LT+1) is taken, otherwise one
  // retry happens and the next WAIT begins at W+LT+1+RC.
  task automatic lock_after(input int d);
    int low, k, rb, t_take, exp_run, exp_retry;
    do_reset();
    wait_resetb_rise(low);
    check_eq("resetb_low", low, RC);
    step(d);
    pll_lock = 1'b1;
    steps_until_locked(k, rb);
    if (d + 3 <= LT + 1) begin
      t_take    = d + 3;
      exp_retry = 0;
    end else begin
      t_take    = (d + 3 > LT + RC + 2) ? d + 3 : LT + RC + 2;
      exp_retry = 1;
    end
    exp_run = t_take + LS + 1;
    check_eq("lock_to_run", d + k, exp_run);
    check_eq("retry_pre_run", rb, exp_retry);
    check_eq("core_reset_run", int'(core_reset), 0);
    check_eq("resetb_run", int'(pll_resetb), 1);
    check_eq("retry_run", int'(retry_count), 0);
  endtask

  // Lock high 5 cycles, low 1, then high: release is timed from the final rise.
  task automatic glitch_lock(input int d);
    int low, k, rb;
    do_reset();
    wait_resetb_rise(low);
    step(d);
    pll_lock = 1'b1;
    step(5);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    steps_until_locked(k, rb);
    check_eq("glitch_run", d + 6 + k, d + 6 + 1 + LS + 3);
    check_eq("glitch_retry", rb, 0);
  endtask

  initial begin
    int low, k, rb, bad;

    do_reset();
    check_reset_values("rst0");

    lock_after(10);
    lock_after(LT - 2);
    lock_after(LT - 1);
    repeat (10) lock_after(int'($urandom_range(LT + RC + 6, 0)));
    repeat (3) glitch_lock(int'($urandom_range(12, 0)));

    // Timeout twice into FAULT, then RESTART.
    do_reset();
    wait_resetb_rise(low);
    check_eq("tmo_low1", low, RC);
    k = 0;
    while (pll_resetb == 1'b1 && k < BOUND) begin step(1); k++; end
    check_eq("tmo_wait1", k, LT + 1);
    check_eq("tmo_retry1", int'(retry_count), 1);
    check_eq("tmo_fault1", int'(fault), 0);
    wait_resetb_rise(low);
    check_eq("tmo_low2", low, RC);
    k = 0;
    while (fault == 1'b0 && k < BOUND) begin step(1); k++; end
    check_eq("tmo_wait2", k, LT + 1);
    check_eq("fault_retry", int'(retry_count), MR);
    check_eq("fault_resetb", int'(pll_resetb), 0);
    check_eq("fault_core", int'(core_reset), 1);
    bad = 0;
    repeat (50) begin
      step(1);
      if (pll_resetb == 1'b1 || fault == 1'b0) bad++;
    end
    check_eq("fault_hold", bad, 0);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_eq("restart_fault", int'(fault), 0);
    check_eq("restart_retry", int'(retry_count), 0);
    check_eq("restart_resetb", int'(pll_resetb), 0);
    wait_resetb_rise(low);
    check_eq("restart_low", low, RC);

    // Loss of lock in RUN and saturation of the loss counter.
    do_reset();
    pll_lock = 1'b1;
    steps_until_locked(k, rb);
    check_eq("loss_locked", int'(locked), 1);
    pll_lock = 1'b0;
    step(2);
    check_eq("loss_hold_core", int'(core_reset), 0);
    step(1);
    check_eq("loss_core", int'(core_reset), 1);
    check_eq("loss_resetb", int'(pll_resetb), 0);
    check_eq("loss_count1", int'(loss_count), 1);
    for (int n = 2; n <= 256; n++) begin
      pll_lock = 1'b1;
      steps_until_locked(k, rb);
      pll_lock = 1'b0;
      step(3);
      check_eq("loss_sat", int'(loss_count), (n > 255) ? 255 : n);
    end

    // One timeout, then lock into STABLE, then RESET while there.
    wait_resetb_rise(low);
    check_eq("stb_low", low, RC);
    k = 0;
    while (pll_resetb == 1'b1 && k < BOUND) begin step(1); k++; end
    check_eq("stb_tmo", k, LT + 1);
    pll_lock = 1'b1;
    wait_resetb_rise(low);
    check_eq("stb_low2", low, RC);
    step(2);
    check_eq("stb_core", int'(core_reset), 1);
    check_eq("stb_resetb", int'(pll_resetb), 1);
    check_eq("stb_retry", int'(retry_count), 1);
    check_eq("stb_loss", int'(loss_count), 255);
    rst = 1'b1;
    step(1);
    check_reset_values("rst_stb");
    rst = 1'b0;
    wait_resetb_rise(low);
    check_eq("rst_stb_low", low, RC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and recovery controller for the iCE40 PLL wrapper. It runs on the PLL reference clock and drives the PLL's active-low reset. It qualifies the PLL lock output and holds the downstream core logic in reset until lock is stable. It retries on lock timeout, restarts on loss of lock, and latches a fault when retries are exhausted.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles PLL_RESETB is held low per attempt (≥2).
- LOCK_TIMEOUT, 4096: max cycles to wait for synchronized lock after PLL_RESETB rises.
- LOCK_STABLE, 256: consecutive synchronized-lock-high cycles required before release (≥1).
- MAX_RETRIES, 3: timeouts tolerated before FAULT (≥1).

Ports:
- REFERENCECLK  in  1  reference clock (PLL input clock); only clock.
- RESET  in  1  synchronous, active-high reset.
- RESTART  in  1  single-cycle request to re-run the sequence and clear retries/fault.
- PLL_LOCK  in  1  PLL LOCK output, treated as asynchronous.
- PLL_RESETB  out  1  to PLL RESETB, active-low.
- CORE_RESET  out  1  active-high reset for PLL-clocked logic. Consumers resynchronize it into their own domain.
- LOCKED  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_COUNT  out  2  timeouts in the current sequence.
- LOSS_COUNT  out  8  saturating count of lock losses while in RUN.

## Operation
- PLL_LOCK passes through a 2-FF synchronizer to produce lock_s.
- States:
  - RST_PLL: PLL_RESETB=0, CORE_RESET=1. Counts RESET_CYCLES cycles, then goes to WAIT.
  - WAIT: PLL_RESETB=1, CORE_RESET=1. Timeout counter runs.
    - lock_s=1: go to STABLE.
    - Counter reaches LOCK_TIMEOUT: RETRY_COUNT++. If the new value equals MAX_RETRIES, go to FAULT; else go to RST_PLL.
  - STABLE: PLL_RESETB=1, CORE_RESET=1. Counts consecutive lock_s=1 cycles.
    - lock_s=0: go to WAIT with the timeout counter restarted at 0.
    - Count reaches LOCK_STABLE: go to RUN.
  - RUN: CORE_RESET=0, LOCKED=1. RETRY_COUNT clears on entry.
    - lock_s=0: LOSS_COUNT++ (saturating at 255), go to RST_PLL.
  - FAULT: PLL_RESETB=0, CORE_RESET=1, FAULT=1. Exits only via RESET or RESTART.
- RESTART is honored in every state. Next state is RST_PLL with all counters restarted and RETRY_COUNT=0. LOSS_COUNT is preserved.
- Priority: RESET > RESTART > lock/timeout transitions. When lock_s rises in the same cycle the timeout expires in WAIT, the lock wins (go to STABLE).
- All outputs are registered and decoded from the state register. There are no combinational paths from inputs to outputs.
- Counter widths are $clog2(max(param)+1). RETRY_COUNT width is fixed at 2, so MAX_RETRIES ≤ 3.

## Timing
- Values while RESET is high and in the cycle after: state RST_PLL, PLL_RESETB=0, CORE_RESET=1, LOCKED=0, FAULT=0, RETRY_COUNT=0, LOSS_COUNT=0, all counters 0.
- PLL_RESETB is low for exactly RESET_CYCLES cycles per attempt.
- PLL_LOCK to lock_s latency is 2 cycles.
- With PLL_LOCK held high, CORE_RESET falls exactly LOCK_STABLE+3 cycles after the first REFERENCECLK edge that samples PLL_LOCK=1. LOCKED rises on the same cycle.
- A PLL_LOCK fall in RUN makes CORE_RESET=1 and PLL_RESETB=0 visible 3 cycles later.
- A timeout attempt lasts RESET_CYCLES+LOCK_TIMEOUT cycles plus 1 transition cycle.
- After RESTART, PLL_RESETB=0 on the next cycle.
- RESET mid-sequence abandons the sequence immediately. No partial state survives.

## Structure
- Package pll_seq_pkg holds:
  - state enum {RST_PLL, WAIT, STABLE, RUN, FAULT};
  - the count-width helper function;
  - the LOSS_COUNT saturation constant (8'hFF).
- Sub-module sync_2ff (1-bit, 2-stage, reset to 0) for PLL_LOCK. It is reusable for other async status inputs.
- Top level is one state register, one shared phase counter (reused across RST_PLL/WAIT/STABLE), and the retry and loss counters.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2.
- Normal lock: RESET, then PLL_LOCK high 10 cycles after PLL_RESETB rises. Required: PLL_RESETB low exactly 4 cycles; CORE_RESET falls 11 cycles after the lock edge; LOCKED=1; RETRY_COUNT=0.
- Glitchy lock: PLL_LOCK high 5 cycles, low 1, then high. Required: return to WAIT; CORE_RESET falls 11 cycles after the final rise.
- Timeout to fault: PLL_LOCK held low. Required: two attempts, then RETRY_COUNT=2 and FAULT=1, with PLL_RESETB=0 thereafter. RESTART then yields FAULT=0, RETRY_COUNT=0, and a fresh 4-cycle PLL_RESETB pulse.
- Loss in RUN: drop PLL_LOCK while LOCKED=1. Required: 3 cycles later CORE_RESET=1, PLL_RESETB=0, LOSS_COUNT=1. 256 losses leave LOSS_COUNT=255.
- Simultaneous: lock_s rises on the timeout cycle → STABLE with RETRY_COUNT unchanged. RESET asserted in STABLE → all reset values next cycle.
